// File: rtl/e_ppn_sub_seq.sv
// ============================================================================
// e_ppn_sub_seq
// ----------------------------------------------------------------------------
// Limb-serial N-bit subtractor with borrow-in, borrow-out and a zero flag.
// It is the subtract/compare partner of the carry-in/carry-out adder in the
// Kaliski modular-inverse datapath. It takes the place of one wide
// single-cycle subtract in the u-v and r-s update paths.
//
// Operands are captured on a valid/ready handshake. The block then processes
// W bits per clock, least significant limb first. The result is held until
// the consumer accepts it.
//
// d_o = (a_i - b_i - bw_i) mod 2^N
// bw_o = 1 when a_i < b_i + bw_i
// zero_o = 1 when d_o == 0
//
// Parameters
//   N : operand and result width in bits
//   W : limb width handled per clock (1 <= W <= N)
//
// Ports
//   clk          : sole clock, rising edge
//   reset        : asynchronous active-high reset
//   in_valid_i   : operands are presented
//   in_ready_o   : block is idle and can accept operands
//   a_i          : minuend, unsigned
//   b_i          : subtrahend, unsigned
//   bw_i         : borrow-in
//   out_valid_o  : result is valid
//   out_ready_i  : consumer takes the result
//   d_o          : difference register (partial limbs show while running)
//   bw_o         : borrow-out
//   zero_o       : difference is all zeros
// ============================================================================
module e_ppn_sub_seq #(
    parameter int N = 257,
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         bw_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] d_o,
    output logic         bw_o,
    output logic         zero_o
);

    // Limb count, width of the (possibly narrower) top limb, and the width of
    // the limb counter. The counter keeps at least one bit so that a
    // single-limb build still elaborates cleanly.
    localparam int L  = (N + W - 1) / W;
    localparam int TW = N - (L - 1) * W;
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_nextState;

    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [CW-1:0]   r_cnt;
    logic            r_borrow;
    logic            r_nonZero;

    logic [W-1:0]    w_aLimb;
    logic [W-1:0]    w_bLimb;
    logic [W:0]      w_diff;
    logic            w_lastLimb;
    logic            w_limbBorrow;
    logic            w_limbNonZero;

    assign w_lastLimb = (r_cnt == LAST);

    // State register. Reset drops any operation in progress straight back to
    // IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. Only one operation is in flight at a
    // time: in_ready_o is high only in IDLE. in_valid_i has no effect outside
    // IDLE, and out_ready_i has no effect outside DONE.
    always_comb begin
        w_nextState = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastLimb) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Select the current limb of each captured operand. Full limbs come from
    // constant slices chosen by the counter. The top limb is zero-extended from
    // its true width, so no slice ever reaches past bit N-1.
    always_comb begin
        w_aLimb = '0;
        w_bLimb = '0;
        for (int k = 0; k < L - 1; k++) begin
            if (r_cnt == CW'(k)) begin
                w_aLimb = r_a[k*W +: W];
                w_bLimb = r_b[k*W +: W];
            end
        end
        if (w_lastLimb) begin
            w_aLimb[TW-1:0] = r_a[N-1 -: TW];
            w_bLimb[TW-1:0] = r_b[N-1 -: TW];
        end
    end

    // Limb subtract at W+1 bits. A full limb takes its borrow from bit W.
    // The top limb takes its borrow at its own narrower width (bit TW). A
    // negative result sets every bit from TW upward, so bit TW is the borrow.
    // The zero test for the top limb looks only at its TW valid bits.
    always_comb begin
        w_diff        = {1'b0, w_aLimb} - {1'b0, w_bLimb} - {{W{1'b0}}, r_borrow};
        w_limbBorrow  = w_lastLimb ? w_diff[TW] : w_diff[W];
        w_limbNonZero = w_lastLimb ? (|w_diff[TW-1:0]) : (|w_diff[W-1:0]);
    end

    // Datapath. Accepting operands captures them, seeds the running borrow
    // with bw_i and clears the limb counter and the nonzero accumulator. Each
    // RUN edge writes one limb into d_o. The zero flag comes from OR-ing each
    // written limb into an accumulator, not from a full-width compare. The
    // flags are latched on the edge that processes the last limb.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_borrow  <= 1'b0;
            r_nonZero <= 1'b0;
            d_o       <= '0;
            bw_o      <= 1'b0;
            zero_o    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid_i) begin
                        r_a       <= a_i;
                        r_b       <= b_i;
                        r_cnt     <= '0;
                        r_borrow  <= bw_i;
                        r_nonZero <= 1'b0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < L - 1; k++) begin
                        if (r_cnt == CW'(k)) begin
                            d_o[k*W +: W] <= w_diff[W-1:0];
                        end
                    end
                    if (w_lastLimb) begin
                        d_o[N-1 -: TW] <= w_diff[TW-1:0];
                        bw_o           <= w_limbBorrow;
                        zero_o         <= ~(r_nonZero | w_limbNonZero);
                    end
                    r_borrow  <= w_limbBorrow;
                    r_nonZero <= r_nonZero | w_limbNonZero;
                    r_cnt     <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_ppn_sub_seq.sv
// ============================================================================
// tb_e_ppn_sub_seq
// ----------------------------------------------------------------------------
// Self-checking bench for e_ppn_sub_seq at its default size (N=257, W=64,
// five limbs). The expected difference, borrow-out and zero flag come from
// exact wide arithmetic on the whole operands, with no reference to limbs.
// ============================================================================
module tb_e_ppn_sub_seq;

    localparam int N = 257;
    localparam int W = 64;
    localparam int L = (N + W - 1) / W;

    logic         clk;
    logic         reset;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         bw_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [N-1:0] d_o;
    logic         bw_o;
    logic         zero_o;

    int testCount;
    int failCount;

    logic [N-1:0] expD;
    logic         expBw;
    logic         expZero;

    e_ppn_sub_seq #(.N(N), .W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .bw_i        (bw_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .d_o         (d_o),
        .bw_o        (bw_o),
        .zero_o      (zero_o)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison in the bench goes through this task.
    task automatic checkVal(input string tag, input logic [N:0] observed, input logic [N:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: exact unsigned arithmetic on whole operands.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bw);
        logic [N+1:0] wideA;
        logic [N+1:0] wideB;
        wideA   = {2'b00, a};
        wideB   = {2'b00, b} + {{(N+1){1'b0}}, bw};
        expBw   = (wideA < wideB);
        expD    = a - b - {{(N-1){1'b0}}, bw};
        expZero = (expD == '0);
    endtask

    function automatic logic [N-1:0] randN();
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < (N + 31) / 32; i++) begin
            r = (r << 32) | {{(N-32){1'b0}}, $urandom()};
        end
        return r;
    endfunction

    // Wait until the block is idle, then present operands for exactly one
    // accepting edge. The wait is bounded.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic bw);
        int guard;
        guard = 0;
        while (!in_ready_o && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkVal("acceptReady", {{N{1'b0}}, in_ready_o}, {{N{1'b0}}, 1'b1});
        a_i        = a;
        b_i        = b;
        bw_i       = bw;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        a_i        = randN();
        b_i        = randN();
        bw_i       = $urandom_range(0, 1) == 1;
    endtask

    // Count edges until out_valid_o rises, up to a fixed bound. Check that the
    // block reports busy on each of those edges, and check the latency.
    task automatic waitResult();
        int cycles;
        cycles = 0;
        while (!out_valid_o && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            checkVal("busyReady", {{N{1'b0}}, in_ready_o}, '0);
        end
        checkVal("latency", (N+1)'(cycles), (N+1)'(L));
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".d"},    {1'b0, d_o},               {1'b0, expD});
        checkVal({tag, ".bw"},   {{N{1'b0}}, bw_o},         {{N{1'b0}}, expBw});
        checkVal({tag, ".zero"}, {{N{1'b0}}, zero_o},       {{N{1'b0}}, expZero});
    endtask

    // One complete operation with out_ready_i held high. The result handshake
    // happens at the first edge in DONE.
    task automatic runOp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b, input logic bw);
        model(a, b, bw);
        applyStimulus(a, b, bw);
        waitResult();
        checkOutput(tag);
        @(posedge clk);
        #1;
        checkVal({tag, ".validDrop"}, {{N{1'b0}}, out_valid_o}, '0);
        checkVal({tag, ".readyBack"}, {{N{1'b0}}, in_ready_o},  {{N{1'b0}}, 1'b1});
    endtask

    initial begin
        logic [N-1:0] va;
        logic [N-1:0] vb;
        logic [N-1:0] vr;

        testCount   = 0;
        failCount   = 0;
        reset       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        a_i         = '0;
        b_i         = '0;
        bw_i        = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkVal("rst.ready", {{N{1'b0}}, in_ready_o},  {{N{1'b0}}, 1'b1});
        checkVal("rst.valid", {{N{1'b0}}, out_valid_o}, '0);
        checkVal("rst.d",     {1'b0, d_o},              '0);
        checkVal("rst.bw",    {{N{1'b0}}, bw_o},        '0);
        checkVal("rst.zero",  {{N{1'b0}}, zero_o},      '0);

        // Basic subtract
        va = N'(5); vb = N'(3);
        runOp("basic", va, vb, 1'b0);

        // Underflow
        va = '0; vb = N'(1);
        runOp("underflow", va, vb, 1'b0);

        // Borrow that crosses a limb boundary
        va = '0; va[64] = 1'b1; vb = N'(1);
        runOp("crossLimb", va, vb, 1'b0);

        // Borrow that reaches the single-bit top limb
        va = '0; va[N-1] = 1'b1; vb = va;
        runOp("topBit", va, vb, 1'b1);

        // Equal operands, without and with borrow-in
        va = randN(); va[N-1] = 1'b1;
        runOp("equalZero", va, va, 1'b0);
        runOp("equalBorrow", va, va, 1'b1);

        // Randomised operands. Some are equal or nearly equal, to exercise
        // the zero flag and long borrow chains.
        for (int t = 0; t < 20; t++) begin
            va = randN();
            case ($urandom_range(0, 3))
                0:       vb = va;
                1:       vb = va + N'(1);
                default: vb = randN();
            endcase
            runOp("random", va, vb, $urandom_range(0, 1) == 1);
        end

        // Back-pressure: result frozen while new requests are ignored
        out_ready_i = 1'b0;
        va = randN(); vb = randN();
        model(va, vb, 1'b0);
        applyStimulus(va, vb, 1'b0);
        waitResult();
        for (int t = 0; t < 10; t++) begin
            in_valid_i = (t % 2) == 0;
            a_i        = randN();
            b_i        = randN();
            bw_i       = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("hold");
            checkVal("hold.ready", {{N{1'b0}}, in_ready_o},  '0);
            checkVal("hold.valid", {{N{1'b0}}, out_valid_o}, {{N{1'b0}}, 1'b1});
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checkVal("release.valid", {{N{1'b0}}, out_valid_o}, '0);
        checkVal("release.ready", {{N{1'b0}}, in_ready_o},  {{N{1'b0}}, 1'b1});
        repeat (8) begin
            @(posedge clk);
            #1;
            checkVal("noSpurious", {{N{1'b0}}, out_valid_o}, '0);
        end

        // Reset two cycles after an accept
        vr = randN();
        applyStimulus(vr, randN(), 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkVal("midRst.valid", {{N{1'b0}}, out_valid_o}, '0);
        checkVal("midRst.ready", {{N{1'b0}}, in_ready_o},  {{N{1'b0}}, 1'b1});
        checkVal("midRst.d",     {1'b0, d_o},              '0);
        checkVal("midRst.bw",    {{N{1'b0}}, bw_o},        '0);
        #2;
        reset = 1'b0;
        va = N'(7); vb = N'(2);
        runOp("afterRst", va, vb, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/e_ppn_sub_seq.md
# e_ppn_sub_seq

Multi-cycle, limb-serial N-bit subtractor with borrow-in/borrow-out and a zero flag. It is the subtraction and compare counterpart to the carry-in/carry-out adder in the Kaliski modular-inverse datapath. Operands are captured on a valid/ready handshake, processed W bits per cycle (least significant limb first), and the result is held under output back-pressure. The block replaces a wide single-cycle subtract in the u−v / r−s update paths, trading latency for area and timing.

## Interface
- N, default 257: operand and result width in bits.
- W, default 64: limb width processed per cycle; legal range 1 ≤ W ≤ N.
- L (localparam) = ceil(N/W): limb count; 5 at defaults, with a top limb width of N−(L−1)·W = 1 bit.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid_i  in  1  operand request.
- in_ready_o  out  1  block can accept operands.
- a_i  in  N  minuend, unsigned.
- b_i  in  N  subtrahend, unsigned.
- bw_i  in  1  borrow-in.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- d_o  out  N  difference.
- bw_o  out  1  borrow-out.
- zero_o  out  1  set when d_o is all zeros.

## Operation
- Function: d_o = (a_i − b_i − bw_i) mod 2^N.
  - bw_o = 1 exactly when a_i < b_i + bw_i (unsigned, exact arithmetic).
  - zero_o = (d_o == 0).
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready_o = 1. When in_valid_i is high, capture a_i, b_i and bw_i into internal registers, clear the limb counter, seed the running borrow with bw_i, and go to RUN. Input buses are don't-care after the accepting edge.
  - RUN: on each edge, process limb j = counter. The limb difference is a_limb − b_limb − borrow, computed at W+1 bits; its low W bits are written into d at bit offset j·W. The running borrow is updated, and the counter increments.
    - The top limb is narrower (N−(L−1)·W bits). Its borrow is taken at that narrower width and is not taken from bit W.
    - On the edge that processes limb L−1, latch bw_o and zero_o and go to DONE.
  - DONE: out_valid_o = 1 and in_ready_o = 0. d_o, bw_o and zero_o are held stable. When out_ready_i is high at an edge, go to IDLE.
- Ordering and flow control:
  - No overlap between operations: in_ready_o is 0 in RUN and DONE.
  - in_valid_i asserted outside IDLE is ignored.
  - out_ready_i outside DONE is ignored.
- zero_o accumulates an OR-reduction of every written limb. It must not be computed as a separate N-wide compare.
- d_o is a register. Partial limbs are visible during RUN; consumers use d_o only when out_valid_o = 1.

## Timing
- Reset values: state = IDLE, in_ready_o = 1, out_valid_o = 0, d_o = 0, bw_o = 0, zero_o = 0, limb counter = 0, running borrow = 0.
- Latency: if operands are accepted at edge e0, out_valid_o goes high immediately after edge e0+L (5 edges at defaults).
- Result handshake: happens at the first edge in DONE with out_ready_i = 1. out_valid_o falls and in_ready_o rises after that edge.
- Throughput: the earliest next accept is edge e0+L+2. Minimum period is L+2 = 7 cycles.
- Back-pressure: DONE persists indefinitely with all outputs frozen.
- Reset mid-operation (RUN or DONE): the operation is aborted and the result discarded. All outputs take reset values asynchronously. The first accept is possible at the first edge after reset deasserts.
- Boundary conditions:
  - W = N gives L = 1 and a single RUN cycle.
  - When W divides N, the top limb is full width.
  - bw_i = 1 with a_i = b_i gives all-ones and bw_o = 1.

## Test plan
- Basic subtract: accept a=5, b=3, bw_i=0 at edge e0, with out_ready_i held high. Required: out_valid_o high after e0+5; d=2, bw_o=0, zero_o=0; in_ready_o returns after e0+6.
- Underflow: a=0, b=1, bw_i=0. Required: d = 2^257−1 (all ones), bw_o=1, zero_o=0.
- Cross-limb borrow: a=2^64, b=1. Required: d = 2^64−1 with limb1..4 = 0, bw_o=0.
- Top-bit borrow: a=2^256, b=2^256, bw_i=1. Required: d all ones, bw_o=1.
- Equality/zero: a=b=0x1ABC…(random 257-bit), bw_i=0. Required: d=0, zero_o=1, bw_o=0.
  - Same operands with bw_i=1. Required: zero_o=0, bw_o=1.
- Back-pressure and ignore: hold out_ready_i=0 for 10 cycles in DONE while pulsing in_valid_i with new operands. Required:
  - d_o, bw_o and zero_o remain stable, and in_ready_o stays 0.
  - After out_ready_i rises, the block returns to IDLE with no spurious second result.
- Reset mid-RUN: assert reset two cycles after accept. Required: out_valid_o=0 and in_ready_o=1 immediately; after release, a=7, b=2 yields d=5 after exactly 5 cycles.
